// File: rtl/multi_rate_tick_gen.sv
// rtl/multi_rate_tick_gen.sv - NUM_CH programmable dividers producing 1-cycle ticks and 50% square waves
// Divisor writes to a running channel are held pending and applied at that channel's wrap.

module multi_rate_tick_gen #(
  parameter int NUM_CH = 2,
  parameter int CNT_W = 16,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {16'd30000, 16'd1250},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ten_mhz_clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_restart,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] div_pend,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  localparam logic [CH_W:0] NUM_CH_V = (CH_W+1)'(NUM_CH);

  logic ch_ok;
  logic wr_ok;

  assign ch_ok = {1'b0, cfg_ch} < NUM_CH_V;
  // Out-of-range writes are always accepted so the requester never stalls on them.
  assign cfg_ready = ch_ok ? ~div_pend[cfg_ch] : 1'b1;
  assign wr_ok = cfg_valid & cfg_ready & ch_ok;

  always_ff @(posedge ten_mhz_clk) begin
    if (reset) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_valid & cfg_ready & ~ch_ok;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] pend_val;
    logic [CNT_W-1:0] last_cnt;
    logic             pend_r;
    logic             tick_r;
    logic             clk_r;
    logic             hit;
    logic             wrap;

    // A divisor of zero behaves as divide-by-one.
    assign last_cnt = (div_act == '0) ? '0 : div_act - 1'b1;
    assign wrap = (cnt == last_cnt);
    assign hit = wr_ok & (cfg_ch == CH_W'(c));

    always_ff @(posedge ten_mhz_clk) begin
      if (reset) begin
        cnt      <= '0;
        div_act  <= DIV_INIT[c*CNT_W +: CNT_W];
        pend_val <= '0;
        pend_r   <= 1'b0;
        tick_r   <= 1'b0;
        clk_r    <= 1'b0;
      end else if (sync_restart) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        clk_r  <= 1'b0;
        pend_r <= 1'b0;
        if (hit) begin
          div_act <= cfg_div;
        end else if (pend_r) begin
          div_act <= pend_val;
        end
      end else if (!ch_en[c]) begin
        cnt    <= '0;
        tick_r <= 1'b0;
        pend_r <= 1'b0;
        if (hit) begin
          div_act <= cfg_div;
        end else if (pend_r) begin
          div_act <= pend_val;
        end
      end else begin
        if (wrap) begin
          cnt    <= '0;
          tick_r <= 1'b1;
          clk_r  <= ~clk_r;
          if (pend_r) begin
            div_act <= pend_val;
            pend_r  <= 1'b0;
          end
        end else begin
          cnt    <= cnt + 1'b1;
          tick_r <= 1'b0;
        end
        // A write landing on the wrap edge must not be consumed by that wrap.
        if (hit) begin
          pend_r   <= 1'b1;
          pend_val <= cfg_div;
        end
      end
    end

    assign div_pend[c] = pend_r;
    assign tick[c]     = tick_r;
    assign clk_out[c]  = clk_r;
  end

endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// tb/tb_multi_rate_tick_gen.sv - directed scoreboard bench for multi_rate_tick_gen
// Expected tick cycles and clk_out levels are queued by the stimulus and popped on each DUT tick.

module tb_multi_rate_tick_gen;

  localparam int NCH = 3;

  typedef struct {
    int cyc;
    bit lvl;
  } exp_t;

  logic            ten_mhz_clk = 1'b0;
  logic            reset;
  logic [NCH-1:0]  ch_en;
  logic            sync_restart;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [1:0]      cfg_ch;
  logic [15:0]     cfg_div;
  logic            cfg_err;
  logic [NCH-1:0]  div_pend;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  clk_out;

  int       cyc = 0;
  int       checks = 0;
  int       failures = 0;
  exp_t     q [NCH][$];
  exp_t     mon_e;
  bit [NCH-1:0] lvl = '0;

  multi_rate_tick_gen #(
    .NUM_CH(NCH),
    .CNT_W(16),
    .DIV_INIT({16'd7, 16'd30000, 16'd1250})
  ) dut (
    .ten_mhz_clk(ten_mhz_clk),
    .reset(reset),
    .ch_en(ch_en),
    .sync_restart(sync_restart),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .cfg_err(cfg_err),
    .div_pend(div_pend),
    .tick(tick),
    .clk_out(clk_out)
  );

  always #50 ten_mhz_clk = ~ten_mhz_clk;

  always @(posedge ten_mhz_clk) cyc <= cyc + 1;

  // Every tick must match the head of its channel queue in cycle and clk_out level.
  always @(negedge ten_mhz_clk) begin
    if (!reset) begin
      for (int c = 0; c < NCH; c++) begin
        if (tick[c]) begin
          checks++;
          assert (q[c].size() > 0) else begin
            failures++;
            $error("FAIL tick_unexpected ch=%0d observed_cyc=%0d expected=none", c, cyc);
          end
          if (q[c].size() > 0) begin
            mon_e = q[c].pop_front();
            checks++;
            assert (cyc === mon_e.cyc) else begin
              failures++;
              $error("FAIL tick_cycle ch=%0d observed=%0d expected=%0d", c, cyc, mon_e.cyc);
            end
            checks++;
            assert (clk_out[c] === mon_e.lvl) else begin
              failures++;
              $error("FAIL clk_out_level ch=%0d observed=%0b expected=%0b", c, clk_out[c], mon_e.lvl);
            end
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge ten_mhz_clk);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge ten_mhz_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ticks(input int c, input int first, input int d, input int n);
    for (int i = 0; i < n; i++) begin
      lvl[c] = ~lvl[c];
      q[c].push_back('{first + i * d, lvl[c]});
    end
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < NCH; c++) chk(tag, q[c].size(), 0);
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] dv);
    cfg_ch = ch;
    cfg_div = dv;
    cfg_valid = 1'b1;
    step(1);
    cfg_valid = 1'b0;
  endtask

  int k0;
  int s;

  initial begin
    reset = 1'b1;
    ch_en = '0;
    sync_restart = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch = '0;
    cfg_div = '0;
    step(3);
    reset = 1'b0;
    chk("rst_tick", tick, 0);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_div_pend", div_pend, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cfg_ready", cfg_ready, 1);

    // Default divisors: ch0 every 1250, ch1 every 30000; 24 ch0 ticks land on ch1's first.
    ch_en = 3'b011;
    k0 = cyc + 1;
    expect_ticks(0, k0 + 1249, 1250, 24);
    expect_ticks(1, k0 + 29999, 30000, 1);
    wait_until(k0 + 29999);
    ch_en = '0;
    step(1);
    drain("default_drain");
    chk("hold_clk_out", clk_out, {1'b0, lvl[1], lvl[0]});

    // Divisor 0 and 1 both tick every cycle.
    cfg_write(2'd0, 16'd0);
    chk("div0_no_pend", div_pend, 0);
    ch_en = 3'b001;
    k0 = cyc + 1;
    expect_ticks(0, k0, 1, 4);
    wait_until(k0 + 3);
    ch_en = '0;
    step(1);
    drain("div0_drain");
    cfg_write(2'd0, 16'd1);
    ch_en = 3'b001;
    k0 = cyc + 1;
    expect_ticks(0, k0, 1, 4);
    wait_until(k0 + 3);
    ch_en = '0;
    step(1);
    drain("div1_drain");

    // Reload to 100 at cnt=500; a held second write of 55 waits for the wrap.
    cfg_write(2'd0, 16'd1250);
    ch_en = 3'b001;
    k0 = cyc + 1;
    expect_ticks(0, k0 + 1249, 1250, 1);
    expect_ticks(0, k0 + 1349, 100, 1);
    expect_ticks(0, k0 + 1404, 55, 2);
    wait_until(k0 + 499);
    cfg_ch = 2'd0;
    cfg_div = 16'd100;
    cfg_valid = 1'b1;
    chk("reload_ready", cfg_ready, 1);
    step(1);
    chk("reload_pend", div_pend, 3'b001);
    cfg_div = 16'd55;
    chk("pend_not_ready", cfg_ready, 0);
    wait_until(k0 + 1248);
    chk("pend_not_ready_late", cfg_ready, 0);
    step(1);
    chk("wrap_ready", cfg_ready, 1);
    chk("wrap_pend_clear", div_pend, 0);
    step(1);
    cfg_valid = 1'b0;
    chk("second_pend", div_pend, 3'b001);
    wait_until(k0 + 1459);
    ch_en = '0;
    step(1);
    drain("reload_drain");

    // Out-of-range channel.
    cfg_ch = 2'd3;
    cfg_div = 16'd9;
    cfg_valid = 1'b1;
    chk("oor_ready", cfg_ready, 1);
    step(1);
    cfg_valid = 1'b0;
    chk("oor_err", cfg_err, 1);
    chk("oor_no_pend", div_pend, 0);
    step(1);
    chk("oor_err_pulse", cfg_err, 0);

    // sync_restart mid-period with a pending ch1 write and a same-cycle ch0 write.
    cfg_write(2'd0, 16'd100);
    cfg_write(2'd1, 16'd40);
    ch_en = 3'b011;
    k0 = cyc + 1;
    expect_ticks(1, k0 + 39, 40, 2);
    wait_until(k0 + 85);
    cfg_write(2'd1, 16'd20);
    chk("sync_pre_pend", div_pend, 3'b010);
    wait_until(k0 + 89);
    sync_restart = 1'b1;
    cfg_ch = 2'd0;
    cfg_div = 16'd30;
    cfg_valid = 1'b1;
    s = k0 + 90;
    lvl = '0;
    expect_ticks(0, s + 30, 30, 2);
    expect_ticks(1, s + 20, 20, 3);
    step(1);
    sync_restart = 1'b0;
    cfg_valid = 1'b0;
    chk("sync_tick", tick, 0);
    chk("sync_clk_out", clk_out, 0);
    chk("sync_div_pend", div_pend, 0);
    wait_until(s + 60);
    ch_en = '0;
    step(1);
    drain("sync_drain");

    // Reset mid-period restores the 1250 divisor.
    cfg_write(2'd0, 16'd100);
    ch_en = 3'b001;
    k0 = cyc + 1;
    expect_ticks(0, k0 + 99, 100, 1);
    wait_until(k0 + 149);
    reset = 1'b1;
    step(1);
    chk("mid_rst_tick", tick, 0);
    chk("mid_rst_clk_out", clk_out, 0);
    chk("mid_rst_div_pend", div_pend, 0);
    chk("mid_rst_cfg_err", cfg_err, 0);
    reset = 1'b0;
    lvl = '0;
    k0 = cyc + 1;
    expect_ticks(0, k0 + 1249, 1250, 2);
    wait_until(k0 + 2499);
    ch_en = '0;
    step(1);
    drain("rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
